// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer handshake bundle for the shared uart_tx arbiter.
// Producers drive valid/data; the arbiter returns a one-hot ready.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer among N_REQ
// byte producers, spacing frames by FRAME_CYCLES + GUARD_CYCLES.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 10,
  parameter int GUARD_CYCLES = 0,
  parameter int ID_W         = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  uart_tx_arbiter_if.slave req,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic [ID_W-1:0]  grant_id,
  output logic             frame_done
);

  localparam int SPACING = FRAME_CYCLES + GUARD_CYCLES;
  localparam int CNT_W   = $clog2(SPACING + 1);

  typedef enum logic [1:0] {
    HOLDOFF,
    IDLE,
    START,
    WAIT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  idx;
  logic             found;
  logic             grant;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant = (state == IDLE) && enable && found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLDOFF;
      cnt   <= CNT_W'(SPACING);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      HOLDOFF: begin
        if (cnt <= CNT_W'(1)) state_nxt = IDLE;
        else cnt_nxt = cnt - CNT_W'(1);
      end
      IDLE: begin
        if (grant) state_nxt = START;
      end
      START: begin
        state_nxt = WAIT;
        cnt_nxt   = CNT_W'(SPACING - 2);
      end
      WAIT: begin
        if (cnt <= CNT_W'(1)) state_nxt = IDLE;
        else cnt_nxt = cnt - CNT_W'(1);
      end
      default: state_nxt = HOLDOFF;
    endcase
  end

  always_comb begin
    tx_start      = (state == START);
    busy          = (state != IDLE);
    frame_done    = (state == WAIT) && (cnt <= CNT_W'(1));
    req.req_ready = grant ? (N_REQ'(1) << win) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= 8'h00;
      grant_id <= '0;
      ptr      <= '0;
    end else if (grant) begin
      tx_data  <= req.req_data[{win, 3'b000} +: 8];
      grant_id <= win;
      if (win == ID_W'(N_REQ - 1)) ptr <= '0;
      else ptr <= win + ID_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (no guard / guard of 3)
// checked every cycle against a transaction-level timing model.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           enable = 1'b1;
  logic [N-1:0]   valid = '0;
  logic [8*N-1:0] data = '0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) if0 ();
  uart_tx_arbiter_if #(.N_REQ(N)) if1 ();

  assign if0.req_valid = valid;
  assign if0.req_data  = data;
  assign if1.req_valid = valid;
  assign if1.req_data  = data;

  logic       ts0, ts1, bz0, bz1, fd0, fd1;
  logic [7:0] td0, td1;
  logic [1:0] gi0, gi1;

  uart_tx_arbiter #(
    .N_REQ(N), .FRAME_CYCLES(10), .GUARD_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(if0),
    .tx_start(ts0), .tx_data(td0), .busy(bz0),
    .grant_id(gi0), .frame_done(fd0)
  );

  uart_tx_arbiter #(
    .N_REQ(N), .FRAME_CYCLES(10), .GUARD_CYCLES(3)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(if1),
    .tx_start(ts1), .tx_data(td1), .busy(bz1),
    .grant_id(gi1), .frame_done(fd1)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Model: cycle counter since reset release plus per-instance schedule.
  int         t;
  int         sp[2] = '{10, 13};
  int         free_at[2];
  int         ptr[2];
  int         start_at[2];
  int         done_at[2];
  int         m_id[2];
  logic [7:0] m_data[2];

  task automatic chk(input string tag, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d t=%0d got %0h exp %0h",
             tag, k, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int k = 0; k < 2; k++) begin
      free_at[k]  = sp[k];
      ptr[k]      = 0;
      start_at[k] = -1;
      done_at[k]  = -1;
      m_id[k]     = 0;
      m_data[k]   = 8'h00;
    end
  endtask

  // Called at a negedge; asserts reset mid-cycle and releases it
  // on a later negedge so that the next cycle() is cycle 0.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_tx_start", k, k ? ts1 : ts0, 0);
      chk("rst_tx_data", k, k ? td1 : td0, 0);
      chk("rst_req_ready", k,
          k ? if1.req_ready : if0.req_ready, 0);
      chk("rst_grant_id", k, k ? gi1 : gi0, 0);
      chk("rst_frame_done", k, k ? fd1 : fd0, 0);
      chk("rst_busy", k, k ? bz1 : bz0, 1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cycle(input logic [N-1:0] v,
                       input logic [8*N-1:0] d,
                       input logic en);
    valid  = v;
    data   = d;
    enable = en;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic         e_busy;
      logic [N-1:0] e_rdy;
      int           w;
      e_busy = (t < free_at[k]);
      e_rdy  = '0;
      w      = -1;
      if (!e_busy && en && (|v)) begin
        for (int s = 0; s < N; s++) begin
          int i;
          i = (ptr[k] + s) % N;
          if (w < 0 && v[i]) w = i;
        end
        e_rdy[w] = 1'b1;
      end
      chk("req_ready", k, k ? if1.req_ready : if0.req_ready, e_rdy);
      chk("busy", k, k ? bz1 : bz0, e_busy);
      chk("tx_start", k, k ? ts1 : ts0, (t == start_at[k]));
      chk("frame_done", k, k ? fd1 : fd0, (t == done_at[k]));
      chk("tx_data", k, k ? td1 : td0, m_data[k]);
      chk("grant_id", k, k ? gi1 : gi0, m_id[k]);
      if (w >= 0) begin
        m_data[k]   = d[8*w +: 8];
        m_id[k]     = w;
        ptr[k]      = (w + 1) % N;
        start_at[k] = t + 1;
        done_at[k]  = t + sp[k] - 1;
        free_at[k]  = t + sp[k];
      end
    end
    t++;
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0]   rv;
    logic [8*N-1:0] rd;
    logic           ren;

    model_reset();
    @(negedge clk);
    valid = 4'b0001;
    data  = 32'h0000_00A5;
    do_reset();

    // Single requester through holdoff and repeated frames.
    repeat (25) cycle(4'b0001, 32'h0000_00A5, 1'b1);

    // All four pending: strict rotation from pointer 0.
    do_reset();
    repeat (60) cycle(4'b1111, 32'h1312_1110, 1'b1);

    // Two requesters; guarded instance spaces frames by 13.
    repeat (40) cycle(4'b0101, 32'h5A00_C300, 1'b1);

    // Enable dropped two cycles after a start pulse.
    for (int i = 0; i < 20 && start_at[0] != t; i++)
      cycle(4'b0010, 32'h0000_7700, 1'b1);
    repeat (2) cycle(4'b0010, 32'h0000_7700, 1'b1);
    repeat (15) cycle(4'b0010, 32'h0000_7800, 1'b0);
    repeat (15) cycle(4'b0010, 32'h0000_7900, 1'b1);

    // Reset four cycles into WAIT.
    for (int i = 0; i < 20 && start_at[0] != t; i++)
      cycle(4'b1000, 32'h3C00_0000, 1'b1);
    repeat (5) cycle(4'b1000, 32'h3C00_0000, 1'b1);
    do_reset();
    repeat (20) cycle(4'b1000, 32'h4D00_0000, 1'b1);

    // Requester 2 pulses once during requester 1's frame.
    do_reset();
    repeat (11) cycle(4'b0010, 32'h0000_2200, 1'b1);
    cycle(4'b0100, 32'h0033_0000, 1'b1);
    repeat (25) cycle(4'b1001, 32'hD400_00E1, 1'b1);

    // Randomized traffic with sporadic enable drops and one reset.
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < N; b++) rv[b] = ($urandom_range(0, 9) < 4);
      rd  = $urandom;
      ren = ($urandom_range(0, 9) != 0);
      if (i == 250) do_reset();
      cycle(rv, rd, ren);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_tx serializer among N_REQ byte producers. Each requester offers a byte on a valid/ready handshake. The arbiter grants one requester, registers its byte and pulses the serializer start. It then blocks further grants until the frame (start bit, 8 data bits, stop bit) plus an optional guard gap has elapsed. It sits between the command/status sources and the single uart_tx instance.

Parameters:
N_REQ, 4, number of requesters (2..16).
FRAME_CYCLES, 10, clocks from serializer start sampling to the serializer accepting a new start; must be >= 10.
GUARD_CYCLES, 0, extra idle-high clocks inserted between frames.
ID_W, $clog2(N_REQ), width of grant_id.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  when low, no new grants; a frame in flight completes normally.
req_valid  in  N_REQ  bit i: requester i has a byte pending.
req_data  in  8*N_REQ  byte of requester i at [8i+7:8i].
req_ready  out  N_REQ  one-hot accept; a transfer occurs when req_valid[i] && req_ready[i].
tx_start  out  1  one-cycle start pulse to uart_tx.start.
tx_data  out  8  registered byte to uart_tx.data, stable from the tx_start cycle until the next accept.
busy  out  1  high while a frame or holdoff window is active.
grant_id  out  ID_W  index of the most recently accepted requester.
frame_done  out  1  one-cycle pulse when a frame's spacing window ends.

Behaviour:
- SPACING = FRAME_CYCLES + GUARD_CYCLES.
- Reset values (asserted immediately on rst_n low):
  - tx_start=0, tx_data=8'h00, req_ready=0, grant_id=0, frame_done=0.
  - RR pointer=0.
  - busy=1, with the holdoff counter loaded to SPACING.
- Reset holdoff:
  - uart_tx has no reset and may be mid-frame when rst_n is pulled.
  - After rst_n deasserts, the arbiter stays in HOLDOFF for SPACING cycles before any grant.
  - Ending HOLDOFF drops busy but does NOT pulse frame_done.
- States:
  - HOLDOFF: counts down to 0, then goes to IDLE.
  - IDLE: busy=0. If enable && any req_valid, grant and go to START.
  - START: tx_start=1 for exactly this cycle, then go to WAIT.
  - WAIT: counts SPACING-2 cycles, then goes to IDLE and pulses frame_done on the last WAIT cycle.
- Grant (IDLE only):
  - Search starts at the pointer and increases modulo N_REQ.
  - The first valid requester i wins.
  - req_ready[i] is driven combinationally high in that same cycle; all other req_ready bits stay 0.
  - On that edge, tx_data <= req_data[i], grant_id <= i, pointer <= (i+1) mod N_REQ.
- Latency and throughput:
  - Accept in cycle A gives tx_start high in cycle A+1, and busy high from A+1.
  - With requests continuously pending, successive tx_start pulses are exactly SPACING cycles apart.
  - The next accept happens in cycle A+SPACING.
- req_ready is 0 in every state except IDLE, and also 0 when enable=0 or no requester is valid.
- enable deasserted during START or WAIT: the frame finishes and frame_done still pulses. No grant is made until enable returns high.
- A requester dropping req_valid before it is granted is legal; it is simply skipped.
- A requester that is granted must hold its data only in the accept cycle.
- Pointer wrap: a grant to N_REQ-1 moves the pointer to 0.
- With a single persistent requester, that requester wins every slot.
- The arbiter never asserts tx_start while uart_tx could be sending; SPACING >= 10 guarantees this.

Test Plan:
1. Reset release, req_valid=4'b0001, data 8'hA5 held from cycle 0.
   -> busy=1 and no req_ready for the first 10 cycles.
   -> Then req_ready[0] pulses and tx_start follows one cycle later with tx_data=8'hA5.
   -> The uart_tx line shows 0, then 1,0,1,0,0,1,0,1, then 1.
2. All four valid continuously, data 8'h10..8'h13.
   -> Grants in order 0,1,2,3,0.
   -> tx_start pulses exactly 10 cycles apart.
   -> grant_id and tx_data track each grant (8'h10, 8'h11, 8'h12, 8'h13, 8'h10).
3. GUARD_CYCLES=3, two requesters valid.
   -> tx_start spacing is 13 cycles.
   -> frame_done pulses once per frame, in the cycle before busy drops.
4. enable dropped 2 cycles after a tx_start.
   -> The frame completes and frame_done pulses.
   -> No req_ready while enable=0.
   -> The next grant comes on the first IDLE cycle after enable returns high.
5. rst_n asserted 4 cycles into WAIT.
   -> All outputs take reset values immediately.
   -> After release there is a full 10-cycle holdoff with no tx_start, and no frame_done for the aborted frame.
6. Requester 2 valid for one cycle while requester 1 is being served.
   -> Requester 2 is skipped.
   -> The next grant goes to the next valid index by round-robin order from pointer=2.
